// File: rtl/enemy_bank.sv
// enemy_bank: multi-slot enemy store with a once-per-frame movement sweep that probes walls
// through a shared 1-cycle lookup port. Define ENEMY_INVULN_EN for post-damage invulnerability.
module enemy_bank #(
    parameter int NUM_ENEMIES   = 8,
    parameter int COORD_W       = 10,
    parameter int HP_W          = 3,
    parameter int SPRITE_SIZE   = 32,
    parameter int SLOW_STEP     = 2,
    parameter int FAST_STEP     = 4,
    parameter int FAST_TYPE     = 3,
    parameter int OFFSCREEN     = 700,
    parameter int INVULN_FRAMES = 8
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           frame_clk,
    input  logic                           clear,
    input  logic [3*NUM_ENEMIES-1:0]       dir_in,
    input  logic                           spawn_valid,
    input  logic [$clog2(NUM_ENEMIES)-1:0] spawn_slot,
    input  logic [COORD_W-1:0]             spawn_x,
    input  logic [COORD_W-1:0]             spawn_y,
    input  logic [1:0]                     spawn_type,
    input  logic [HP_W-1:0]                spawn_hp,
    input  logic                           dmg_valid,
    input  logic [$clog2(NUM_ENEMIES)-1:0] dmg_slot,
    input  logic [HP_W-1:0]                dmg_amt,
    output logic [COORD_W-1:0]             wall_x,
    output logic [COORD_W-1:0]             wall_y,
    input  logic                           wall_hit,
    input  logic [$clog2(NUM_ENEMIES)-1:0] rd_slot,
    output logic [COORD_W-1:0]             rd_x,
    output logic [COORD_W-1:0]             rd_y,
    output logic [1:0]                     rd_type,
    output logic                           rd_active,
    output logic [$clog2(NUM_ENEMIES):0]   active_count,
    output logic                           room_clear,
    output logic                           busy,
    output logic                           frame_overrun,
    output logic [2:0]                     sweep_state
);
    localparam int IW = $clog2(NUM_ENEMIES);
    localparam int CW = IW + 1;
    localparam logic [COORD_W-1:0]        OFF    = COORD_W'(OFFSCREEN);
    localparam logic [1:0]                FAST_T = 2'(FAST_TYPE);
    localparam logic signed [COORD_W:0]   SLOW_D = (COORD_W+1)'(SLOW_STEP);
    localparam logic signed [COORD_W:0]   FAST_D = (COORD_W+1)'(FAST_STEP);
    localparam logic signed [COORD_W+1:0] SZ     = (COORD_W+2)'(SPRITE_SIZE);
    localparam logic [IW-1:0]             LAST   = IW'(NUM_ENEMIES-1);
    localparam logic [2:0] DIR_L = 3'd1, DIR_R = 3'd2, DIR_D = 3'd3, DIR_U = 3'd4;

    typedef enum logic [2:0] {IDLE, SELECT, PROBE0, PROBE1, SAMPLE, COMMIT} state_t;
    state_t state, state_next;

    logic [COORD_W-1:0]   pos_x [NUM_ENEMIES];
    logic [COORD_W-1:0]   pos_y [NUM_ENEMIES];
    logic [1:0]           kind  [NUM_ENEMIES];
    logic [HP_W-1:0]      hp    [NUM_ENEMIES];
    logic [2:0]           dirs  [NUM_ENEMIES];
    logic [NUM_ENEMIES-1:0] act;

    logic                      frame_q, tick, last, moving;
    logic [IW-1:0]             idx;
    logic [2:0]                cur_dir, dir_q;
    logic signed [COORD_W:0]   step, base_x, base_y, next_x, next_y, cand_x, cand_y;
    logic signed [COORD_W+1:0] ex, ey, ax, ay, bx, by;
    logic                      bad_a, bad_b, hit_a, hit_b;
    logic                      spawn_ok, dmg_ok, commit_ok, kill, kill_q;
    logic [HP_W-1:0]           dmg_hp;
    logic [CW-1:0]             pop;

`ifdef ENEMY_INVULN_EN
    localparam int IVW = $clog2(INVULN_FRAMES + 1);
    logic [IVW-1:0] inv [NUM_ENEMIES];
`endif

    always_comb begin
        for (int i = 0; i < NUM_ENEMIES; i++) dirs[i] = dir_in[i*3 +: 3];
    end

    assign tick    = frame_clk & ~frame_q;
    assign last    = (idx == LAST);
    assign cur_dir = dirs[idx];
    assign moving  = act[idx] && (cur_dir >= DIR_L) && (cur_dir <= DIR_U);
    assign step    = (kind[idx] == FAST_T) ? FAST_D : SLOW_D;
    assign base_x  = {1'b0, pos_x[idx]};
    assign base_y  = {1'b0, pos_y[idx]};

    always_comb begin
        next_x = base_x;
        next_y = base_y;
        case (cur_dir)
            DIR_L:   next_x = base_x - step;
            DIR_R:   next_x = base_x + step;
            DIR_D:   next_y = base_y + step;
            DIR_U:   next_y = base_y - step;
            default: ;
        endcase
    end

    // Corners carry two extra bits: the sign flags a negative candidate, bit COORD_W an
    // address past the edge; either is a wall without consulting the lookup.
    assign ex = {cand_x[COORD_W], cand_x};
    assign ey = {cand_y[COORD_W], cand_y};

    always_comb begin
        ax = ex;
        ay = ey;
        bx = ex;
        by = ey;
        case (dir_q)
            DIR_L:   by = ey + SZ;
            DIR_R:   begin ax = ex + SZ; bx = ex + SZ; by = ey + SZ; end
            DIR_D:   begin ay = ey + SZ; bx = ex + SZ; by = ey + SZ; end
            DIR_U:   bx = ex + SZ;
            default: ;
        endcase
    end

    assign bad_a = ax[COORD_W+1] | ax[COORD_W] | ay[COORD_W+1] | ay[COORD_W];
    assign bad_b = bx[COORD_W+1] | bx[COORD_W] | by[COORD_W+1] | by[COORD_W];

    always_comb begin
        wall_x = '0;
        wall_y = '0;
        if (state == PROBE0) begin
            wall_x = ax[COORD_W-1:0];
            wall_y = ay[COORD_W-1:0];
        end else if (state == PROBE1) begin
            wall_x = bx[COORD_W-1:0];
            wall_y = by[COORD_W-1:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = SELECT;
            SELECT:  if (moving) state_next = PROBE0;
                     else if (last) state_next = IDLE;
            PROBE0:  state_next = PROBE1;
            PROBE1:  state_next = SAMPLE;
            SAMPLE:  state_next = COMMIT;
            COMMIT:  state_next = last ? IDLE : SELECT;
            default: state_next = IDLE;
        endcase
        if (clear) state_next = IDLE;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idx    <= '0;
            dir_q  <= '0;
            cand_x <= '0;
            cand_y <= '0;
            hit_a  <= 1'b0;
            hit_b  <= 1'b0;
        end else begin
            case (state)
                IDLE:    idx <= '0;
                SELECT:  begin
                    dir_q  <= cur_dir;
                    cand_x <= next_x;
                    cand_y <= next_y;
                    if (!moving && !last) idx <= idx + IW'(1);
                end
                PROBE1:  hit_a <= wall_hit | bad_a;
                SAMPLE:  hit_b <= wall_hit | bad_b;
                COMMIT:  if (!last) idx <= idx + IW'(1);
                default: ;
            endcase
        end
    end

    // Per-slot write priority: clear > spawn > damage > commit.
    assign spawn_ok = spawn_valid && (spawn_hp != '0);
    assign dmg_hp   = (hp[dmg_slot] > dmg_amt) ? hp[dmg_slot] - dmg_amt : '0;
`ifdef ENEMY_INVULN_EN
    assign dmg_ok = dmg_valid && act[dmg_slot] && (inv[dmg_slot] == '0)
                    && !(spawn_ok && spawn_slot == dmg_slot);
`else
    assign dmg_ok = dmg_valid && act[dmg_slot] && !(spawn_ok && spawn_slot == dmg_slot);
`endif
    assign commit_ok = (state == COMMIT) && act[idx] && !(spawn_ok && spawn_slot == idx)
                       && !(dmg_ok && dmg_slot == idx);
    assign kill      = dmg_ok && (dmg_hp == '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                act[i]   <= 1'b0;
                pos_x[i] <= OFF;
                pos_y[i] <= OFF;
                kind[i]  <= '0;
                hp[i]    <= '0;
`ifdef ENEMY_INVULN_EN
                inv[i]   <= '0;
`endif
            end
        end else begin
            if (commit_ok) begin
                if (!(hit_a | hit_b)) begin
                    pos_x[idx] <= cand_x[COORD_W-1:0];
                    pos_y[idx] <= cand_y[COORD_W-1:0];
                end else begin
                    case (dir_q)
                        DIR_L:   pos_x[idx] <= pos_x[idx] + COORD_W'(1);
                        DIR_R:   pos_x[idx] <= pos_x[idx] - COORD_W'(1);
                        DIR_D:   pos_y[idx] <= pos_y[idx] - COORD_W'(1);
                        DIR_U:   pos_y[idx] <= pos_y[idx] + COORD_W'(1);
                        default: ;
                    endcase
                end
            end
`ifdef ENEMY_INVULN_EN
            if (tick) begin
                for (int i = 0; i < NUM_ENEMIES; i++)
                    if (inv[i] != '0) inv[i] <= inv[i] - IVW'(1);
            end
`endif
            if (dmg_ok) begin
                hp[dmg_slot] <= dmg_hp;
                if (dmg_hp == '0) begin
                    act[dmg_slot]   <= 1'b0;
                    pos_x[dmg_slot] <= OFF;
                    pos_y[dmg_slot] <= OFF;
                end
`ifdef ENEMY_INVULN_EN
                else inv[dmg_slot] <= IVW'(INVULN_FRAMES);
`endif
            end
            if (spawn_ok) begin
                act[spawn_slot]   <= 1'b1;
                pos_x[spawn_slot] <= spawn_x;
                pos_y[spawn_slot] <= spawn_y;
                kind[spawn_slot]  <= spawn_type;
                hp[spawn_slot]    <= spawn_hp;
`ifdef ENEMY_INVULN_EN
                inv[spawn_slot]   <= '0;
`endif
            end
            if (clear) begin
                for (int i = 0; i < NUM_ENEMIES; i++) begin
                    act[i]   <= 1'b0;
                    pos_x[i] <= OFF;
                    pos_y[i] <= OFF;
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) pop = pop + CW'(act[i]);
    end

    // kill_q marks that the flags now in act were last changed by a damage kill.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_q       <= 1'b0;
            active_count  <= '0;
            kill_q        <= 1'b0;
            room_clear    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            frame_q       <= frame_clk;
            active_count  <= pop;
            kill_q        <= kill && !clear;
            room_clear    <= kill_q && (pop == '0) && (active_count != '0) && !clear;
            frame_overrun <= tick && (state != IDLE) && !clear;
        end
    end

    assign busy        = (state != IDLE);
    assign sweep_state = state;
    assign rd_active   = act[rd_slot];
    assign rd_x        = act[rd_slot] ? pos_x[rd_slot] : OFF;
    assign rd_y        = act[rd_slot] ? pos_y[rd_slot] : OFF;
    assign rd_type     = kind[rd_slot];

endmodule

// File: tb/tb_enemy_bank.sv
// Directed bench for enemy_bank: spawn, movement sweep, wall probing, damage, clear.
module tb_enemy_bank;
    localparam int N = 8;
    localparam int W = 10;

    logic             Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, clear = 1'b0;
    logic [3*N-1:0]   dir_in = '0;
    logic             spawn_valid = 1'b0, dmg_valid = 1'b0;
    logic [2:0]       spawn_slot = '0, dmg_slot = '0, rd_slot = '0;
    logic [W-1:0]     spawn_x = '0, spawn_y = '0;
    logic [1:0]       spawn_type = '0;
    logic [2:0]       spawn_hp = '0, dmg_amt = '0;
    logic [W-1:0]     wall_x, wall_y, rd_x, rd_y;
    logic             wall_hit;
    logic [1:0]       rd_type;
    logic             rd_active, room_clear, busy, frame_overrun;
    logic [3:0]       active_count;
    logic [2:0]       sweep_state;

    logic             hit_en = 1'b0, track = 1'b0;
    logic [W-1:0]     hit_x = '0, hit_y = '0;
    logic [2*W-1:0]   exp_q[$];
    int               checks = 0, errors = 0, busy_cycles = 0;

    enemy_bank dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .clear(clear), .dir_in(dir_in),
        .spawn_valid(spawn_valid), .spawn_slot(spawn_slot), .spawn_x(spawn_x),
        .spawn_y(spawn_y), .spawn_type(spawn_type), .spawn_hp(spawn_hp),
        .dmg_valid(dmg_valid), .dmg_slot(dmg_slot), .dmg_amt(dmg_amt),
        .wall_x(wall_x), .wall_y(wall_y), .wall_hit(wall_hit), .rd_slot(rd_slot),
        .rd_x(rd_x), .rd_y(rd_y), .rd_type(rd_type), .rd_active(rd_active),
        .active_count(active_count), .room_clear(room_clear), .busy(busy),
        .frame_overrun(frame_overrun), .sweep_state(sweep_state)
    );

    always #5 Clk = ~Clk;

    // Level lookup model: a single wall pixel, answered one cycle after the address.
    always @(posedge Clk) wall_hit <= hit_en && (wall_x == hit_x) && (wall_y == hit_y);

    initial begin
        #2000000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_slot(input string tag, input int s, input int a, input int x, input int y);
        rd_slot = 3'(s);
        #1;
        check({tag, "_active"}, rd_active, a);
        check({tag, "_x"}, rd_x, x);
        check({tag, "_y"}, rd_y, y);
    endtask

    task automatic set_dir(input int s, input logic [2:0] d);
        dir_in[s*3 +: 3] = d;
    endtask

    task automatic spawn(input int s, input int x, input int y, input int t, input int h);
        spawn_valid = 1'b1;
        spawn_slot  = 3'(s);
        spawn_x     = W'(x);
        spawn_y     = W'(y);
        spawn_type  = 2'(t);
        spawn_hp    = 3'(h);
        step();
        spawn_valid = 1'b0;
    endtask

    task automatic damage(input int s, input int a);
        dmg_valid = 1'b1;
        dmg_slot  = 3'(s);
        dmg_amt   = 3'(a);
        step();
        dmg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            n++;
            if (track && (wall_x != '0 || wall_y != '0)) begin
                if (exp_q.size() != 0) begin
                    check("probe_addr", {12'd0, wall_x, wall_y}, {12'd0, exp_q.pop_front()});
                end else begin
                    checks++;
                    errors++;
                    $error("FAIL probe_extra observed %0d,%0d expected none", wall_x, wall_y);
                end
            end
            step();
        end
        busy_cycles = n;
        check("sweep_end", busy, 0);
    endtask

    task automatic run_sweep();
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        wait_idle();
    endtask

    initial begin
        // Reset state
        step();
        step();
        Reset = 1'b0;
        step();
        for (int i = 0; i < N; i++) check_slot("reset", i, 0, 700, 700);
        check("reset_count", active_count, 0);
        check("reset_busy", busy, 0);
        check("reset_room_clear", room_clear, 0);
        check("reset_overrun", frame_overrun, 0);
        check("reset_wall", {wall_x, wall_y}, 0);

        // Fast type moving right, no walls
        set_dir(2, 3'd2);
        spawn(2, 64, 64, 3, 2);
        check_slot("spawn2", 2, 1, 64, 64);
        check("spawn2_type", rd_type, 3);
        step();
        check("count_one", active_count, 1);
        run_sweep();
        check("busy_len_one", busy_cycles, 12);
        check_slot("move_fast", 2, 1, 68, 64);

        // Slow type moving left, corner B hits a wall
        set_dir(0, 3'd1);
        spawn(0, 100, 100, 1, 1);
        hit_x = 10'd98;
        hit_y = 10'd132;
        hit_en = 1'b1;
        track = 1'b1;
        exp_q.push_back({10'd98, 10'd100});
        exp_q.push_back({10'd98, 10'd132});
        exp_q.push_back({10'd104, 10'd64});
        exp_q.push_back({10'd104, 10'd96});
        run_sweep();
        track = 1'b0;
        hit_en = 1'b0;
        check("busy_len_two", busy_cycles, 16);
        check("probe_left", exp_q.size(), 0);
        check_slot("wall_nudge", 0, 1, 101, 100);
        check_slot("move_fast2", 2, 1, 72, 64);

        // Damage, saturation, kill and room_clear
        spawn(1, 200, 200, 0, 3);
        step();
        check("count_three", active_count, 3);
        damage(1, 1);
        check_slot("dmg_partial", 1, 1, 200, 200);
        damage(1, 5);
`ifdef ENEMY_INVULN_EN
        check_slot("dmg_invuln", 1, 1, 200, 200);
        for (int k = 0; k < 8; k++) run_sweep();
        damage(1, 5);
`endif
        check_slot("dmg_kill", 1, 0, 700, 700);
        step();
        check("count_two", active_count, 2);
        check("no_room_clear", room_clear, 0);
        damage(0, 7);
        check_slot("kill0", 0, 0, 700, 700);
        damage(2, 7);
        check("rc_not_yet", room_clear, 0);
        step();
        check("rc_pulse", room_clear, 1);
        check("count_zero", active_count, 0);
        step();
        check("rc_one_cycle", room_clear, 0);
        damage(5, 1);
        check_slot("dmg_inactive", 5, 0, 700, 700);
        step();
        check("rc_inactive_dmg", room_clear, 0);

        // Spawn and damage to the same slot in one cycle
        spawn(4, 10, 10, 0, 2);
        spawn_valid = 1'b1;
        spawn_slot = 3'd4;
        spawn_x = 10'd300;
        spawn_y = 10'd300;
        spawn_type = 2'd2;
        spawn_hp = 3'd1;
        dmg_valid = 1'b1;
        dmg_slot = 3'd4;
        dmg_amt = 3'd3;
        step();
        spawn_valid = 1'b0;
        dmg_valid = 1'b0;
        check_slot("spawn_wins", 4, 1, 300, 300);
        check("spawn_wins_type", rd_type, 2);
        damage(4, 1);
        check_slot("spawn_hp_one", 4, 0, 700, 700);
        step();
        check("rc_slot4", room_clear, 1);

        // Frame edge while busy
        set_dir(4, 3'd4);
        spawn(4, 300, 300, 0, 3);
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        check("sweep_started", busy, 1);
        check("no_overrun_yet", frame_overrun, 0);
        step();
        frame_clk = 1'b1;
        step();
        check("overrun_pulse", frame_overrun, 1);
        frame_clk = 1'b0;
        step();
        check("overrun_one_cycle", frame_overrun, 0);
        wait_idle();
        check_slot("move_up", 4, 1, 300, 298);
        step();
        step();
        step();
        check("no_second_sweep", busy, 0);
        check_slot("moved_once", 4, 1, 300, 298);

        // clear during PROBE1 of slot 3
        set_dir(3, 3'd2);
        spawn(3, 400, 400, 0, 2);
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        repeat (5) step();
        check("at_probe1", sweep_state, 3);
        check("probe1_x", wall_x, 434);
        check("probe1_y", wall_y, 432);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_busy", busy, 0);
        check("clear_state", sweep_state, 0);
        check_slot("clear3", 3, 0, 700, 700);
        check_slot("clear4", 4, 0, 700, 700);
        check("clear_no_rc", room_clear, 0);
        step();
        check("clear_count", active_count, 0);
        check("clear_no_rc2", room_clear, 0);

        // Edge-of-screen candidates and ignored zero-hp spawn
        set_dir(0, 3'd1);
        set_dir(1, 3'd2);
        spawn(0, 1, 50, 0, 1);
        spawn(1, 990, 50, 3, 1);
        spawn(6, 20, 20, 0, 0);
        check_slot("spawn_hp0", 6, 0, 700, 700);
        run_sweep();
        check("busy_len_edge", busy_cycles, 16);
        check_slot("edge_left", 0, 1, 2, 50);
        check_slot("edge_right", 1, 1, 989, 50);
        check("idle_wall", {wall_x, wall_y}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
